// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic matrix-multiply engine:
// FSM state encoding, arithmetic mode codes and sizing helpers.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DRAIN
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Cycles needed for the last injected operand pair to reach PE(N-1,N-1).
  function automatic int flush_cycles(input int arr_size);
    return 2 * arr_size - 1;
  endfunction

  function automatic int idx_width(input int arr_size);
    return (arr_size > 1) ? $clog2(arr_size) : 1;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Operand input stream and result output stream of the systolic engine,
// both valid/ready. The engine takes the slave modport.
interface systolic_mm_engine_if
  import systolic_pkg::*;
#(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40
);
  localparam int IDX_W = idx_width(ARR_SIZE);

  logic                         in_valid;
  logic                         in_ready;
  logic [ARR_SIZE*DATA_W-1:0]   a_vec;
  logic [ARR_SIZE*DATA_W-1:0]   b_vec;
  logic                         out_valid;
  logic                         out_ready;
  logic [ARR_SIZE*ACC_W-1:0]    out_row;
  logic [IDX_W-1:0]             out_idx;

  modport master (
    output in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_idx
  );

  modport slave (
    input  in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_idx
  );

endinterface

// File: rtl/systolic_acc_pe.sv
// Output-stationary processing element: forwards A right and B down through one
// register each and accumulates A*B. SYSTOLIC_SATURATE_EN enables clamping + sticky ovf.
module systolic_acc_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mode,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
`ifdef SYSTOLIC_SATURATE_EN
  ,
  output logic              ovf
`endif
);
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam int EXT_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;

  // One extra bit per operand lets a single signed multiplier serve both modes.
  logic signed [DATA_W:0]   a_x;
  logic signed [DATA_W:0]   b_x;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [EXT_W-1:0]  prod_wide;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W:0]           sum;

  assign a_x       = {(mode == MODE_SIGNED) & a_in[DATA_W-1], a_in};
  assign b_x       = {(mode == MODE_SIGNED) & b_in[DATA_W-1], b_in};
  assign prod_full = PROD_W'(a_x) * PROD_W'(b_x);
  assign prod_wide = EXT_W'(prod_full);
  assign prod_ext  = prod_wide[ACC_W-1:0];
  assign sum       = {1'b0, acc} + {1'b0, prod_ext};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
    end else if (clear) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
    end
  end

`ifdef SYSTOLIC_SATURATE_EN
  logic             s_ovf;
  logic             u_ovf;
  logic             hit;
  logic [ACC_W-1:0] sat_val;

  assign s_ovf   = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign u_ovf   = sum[ACC_W];
  assign hit     = (mode == MODE_SIGNED) ? s_ovf : u_ovf;
  assign sat_val = (mode == MODE_UNSIGNED) ? {ACC_W{1'b1}} :
                   acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  // Once clamped, the accumulator holds for the rest of the job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (!ovf) begin
      if (hit) begin
        acc <= sat_val;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else begin
      acc <= sum[ACC_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/systolic_mm_engine.sv
// ARR_SIZE x ARR_SIZE output-stationary systolic matrix-multiply engine with input
// skew, control FSM and row drain. Define SYSTOLIC_SATURATE_EN for saturation and o_ovf.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int K_W      = 9
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_mode,
  input  logic [K_W-1:0] i_k_len,
  systolic_mm_engine_if.slave bus,
  output logic           busy,
  output logic           done
`ifdef SYSTOLIC_SATURATE_EN
  ,
  output logic           o_ovf
`endif
);
  localparam int IDX_W        = idx_width(ARR_SIZE);
  localparam int FLUSH_CYCLES = flush_cycles(ARR_SIZE);
  localparam int FC_W         = $clog2(FLUSH_CYCLES + 1);

  state_t           state_reg;
  logic             mode_reg;
  logic [K_W-1:0]   k_len_reg;
  logic [K_W-1:0]   beat_cnt_reg;
  logic [FC_W-1:0]  flush_cnt_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [IDX_W-1:0] out_idx_reg;
  logic             busy_reg;
  logic             done_reg;

  logic clear;
  logic beat;

  assign clear = (state_reg == IDLE) && i_start;
  assign beat  = in_ready_reg && bus.in_valid;

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_idx   = out_idx_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      mode_reg      <= MODE_UNSIGNED;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            mode_reg      <= i_mode;
            k_len_reg     <= i_k_len;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            if (i_k_len == '0) begin
              state_reg <= FLUSH;
            end else begin
              state_reg    <= STREAM;
              in_ready_reg <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + K_W'(1);
            if ((beat_cnt_reg + K_W'(1)) == k_len_reg) begin
              state_reg     <= FLUSH;
              in_ready_reg  <= 1'b0;
              flush_cnt_reg <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_reg == FC_W'(FLUSH_CYCLES - 1)) begin
            state_reg     <= DRAIN;
            out_valid_reg <= 1'b1;
            out_idx_reg   <= '0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + FC_W'(1);
          end
        end
        DRAIN: begin
          // out_valid is always high here, so out_ready alone completes a handshake.
          if (bus.out_ready) begin
            if (out_idx_reg == IDX_W'(ARR_SIZE - 1)) begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
              out_idx_reg   <= '0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
            end else begin
              out_idx_reg <= out_idx_reg + IDX_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] a_inj [ARR_SIZE];
  logic [DATA_W-1:0] b_inj [ARR_SIZE];
  logic [DATA_W-1:0] a_skw [ARR_SIZE];
  logic [DATA_W-1:0] b_skw [ARR_SIZE];

  genvar gi, gj;
  generate
    for (gi = 0; gi < ARR_SIZE; gi++) begin : g_lane
      // Idle cycles inject zero operands so they contribute nothing to the sums.
      assign a_inj[gi] = beat ? bus.a_vec[gi*DATA_W +: DATA_W] : '0;
      assign b_inj[gi] = beat ? bus.b_vec[gi*DATA_W +: DATA_W] : '0;
      if (gi == 0) begin : g_direct
        assign a_skw[gi] = a_inj[gi];
        assign b_skw[gi] = b_inj[gi];
      end else begin : g_skew
        logic [DATA_W-1:0] a_sr [gi];
        logic [DATA_W-1:0] b_sr [gi];
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            for (int i = 0; i < gi; i++) begin
              a_sr[i] <= '0;
              b_sr[i] <= '0;
            end
          end else if (clear) begin
            for (int i = 0; i < gi; i++) begin
              a_sr[i] <= '0;
              b_sr[i] <= '0;
            end
          end else begin
            a_sr[0] <= a_inj[gi];
            b_sr[0] <= b_inj[gi];
            for (int i = 1; i < gi; i++) begin
              a_sr[i] <= a_sr[i-1];
              b_sr[i] <= b_sr[i-1];
            end
          end
        end
        assign a_skw[gi] = a_sr[gi-1];
        assign b_skw[gi] = b_sr[gi-1];
      end
    end
  endgenerate

  logic [DATA_W-1:0] a_h [ARR_SIZE][ARR_SIZE+1];
  logic [DATA_W-1:0] b_v [ARR_SIZE+1][ARR_SIZE];
  logic [ACC_W-1:0]  acc [ARR_SIZE][ARR_SIZE];
`ifdef SYSTOLIC_SATURATE_EN
  logic [ARR_SIZE*ARR_SIZE-1:0] ovf_flags;
  assign o_ovf = |ovf_flags;
`endif

  generate
    for (gi = 0; gi < ARR_SIZE; gi++) begin : g_edge
      assign a_h[gi][0] = a_skw[gi];
      assign b_v[0][gi] = b_skw[gi];
    end
    for (gi = 0; gi < ARR_SIZE; gi++) begin : g_row
      for (gj = 0; gj < ARR_SIZE; gj++) begin : g_col
        systolic_acc_pe #(
          .DATA_W (DATA_W),
          .ACC_W  (ACC_W)
        ) u_pe (
          .clk   (clk),
          .rst   (rst),
          .clear (clear),
          .mode  (mode_reg),
          .a_in  (a_h[gi][gj]),
          .b_in  (b_v[gi][gj]),
          .a_out (a_h[gi][gj+1]),
          .b_out (b_v[gi+1][gj]),
          .acc   (acc[gi][gj])
`ifdef SYSTOLIC_SATURATE_EN
          ,
          .ovf   (ovf_flags[gi*ARR_SIZE+gj])
`endif
        );
      end
    end
    for (gi = 0; gi < ARR_SIZE; gi++) begin : g_out
      assign bus.out_row[gi*ACC_W +: ACC_W] = out_valid_reg ? acc[out_idx_reg][gi] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed self-checking bench for systolic_mm_engine (4x4, 16-bit operands, 40-bit acc).
module tb_systolic_mm_engine;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int AW    = 40;
  localparam int KW    = 9;
  localparam int ROW_W = N * AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_mode = 1'b0;
  logic [KW-1:0] i_k_len = '0;
  logic          busy;
  logic          done;
`ifdef SYSTOLIC_SATURATE_EN
  logic          ovf;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] a_mat [8][N];
  logic [DW-1:0] b_mat [8][N];
  logic [AW-1:0] exp_c [N][N];

  systolic_mm_engine_if #(.ARR_SIZE(N), .DATA_W(DW), .ACC_W(AW)) bus ();

  systolic_mm_engine #(
    .ARR_SIZE (N),
    .DATA_W   (DW),
    .ACC_W    (AW),
    .K_W      (KW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_mode  (i_mode),
    .i_k_len (i_k_len),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
`ifdef SYSTOLIC_SATURATE_EN
    ,
    .o_ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] pack_a(input int k);
    logic [N*DW-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = a_mat[k][r];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int k);
    logic [N*DW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = b_mat[k][c];
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input int r);
    logic [ROW_W-1:0] v;
    for (int c = 0; c < N; c++) v[c*AW +: AW] = exp_c[r][c];
    return v;
  endfunction

  task automatic golden(input logic mode, input int k);
    longint s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          if (mode) s += longint'($signed(a_mat[kk][r])) * longint'($signed(b_mat[kk][c]));
          else      s += longint'(a_mat[kk][r]) * longint'(b_mat[kk][c]);
        end
        exp_c[r][c] = s[AW-1:0];
      end
  endtask

  task automatic run_job(input string name, input logic mode, input int k, input int gap,
                         input int stall_row, input int stall_len);
    int   beats;
    int   budget;
    int   last_cyc;
    int   hold;
    logic saw_ready;
    i_mode  = mode;
    i_k_len = KW'(k);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check_eq({name, " busy_after_start"}, busy, 1'b1);
    beats = 0; budget = 0; last_cyc = 0; saw_ready = 1'b0;
    while (beats < k && budget < 200) begin
      bus.a_vec    = pack_a(beats);
      bus.b_vec    = pack_b(beats);
      bus.in_valid = 1'b1;
      if (bus.in_ready) begin
        last_cyc = cyc;
        beats++;
      end
      step();
      budget++;
      if (beats < k) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          bus.a_vec    = '1;
          bus.b_vec    = '1;
          i_start      = 1'b1;
          step();
          budget++;
        end
      end
      i_start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.a_vec    = '0;
    bus.b_vec    = '0;
    check_eq({name, " beats_accepted"}, beats, k);
    check_eq({name, " in_ready_after_last"}, bus.in_ready, 1'b0);
    budget = 0;
    while (!bus.out_valid && budget < 100) begin
      if (bus.in_ready) saw_ready = 1'b1;
      step();
      budget++;
    end
    check_eq({name, " out_valid_seen"}, bus.out_valid, 1'b1);
    if (k > 0) check_eq({name, " latency"}, cyc - last_cyc, 2 * N);
    else       check_eq({name, " in_ready_never"}, saw_ready, 1'b0);
`ifdef SYSTOLIC_SATURATE_EN
    check_eq({name, " ovf_clear"}, ovf, 1'b0);
`endif
    for (int r = 0; r < N; r++) begin
      hold = (r == stall_row) ? stall_len : 0;
      for (int h = 0; h <= hold; h++) begin
        bus.out_ready = (h == hold);
        check_eq($sformatf("%s row%0d_valid", name, r), bus.out_valid, 1'b1);
        check_eq($sformatf("%s row%0d_idx", name, r), bus.out_idx, r);
        check_eq($sformatf("%s row%0d_data", name, r), bus.out_row, exp_row(r));
        check_eq($sformatf("%s row%0d_done_low", name, r), done, 1'b0);
        if (h == hold) $display("job %s row %0d idx %0d data %h", name, r, bus.out_idx, bus.out_row);
        step();
      end
    end
    bus.out_ready = 1'b0;
    check_eq({name, " done_pulse"}, done, 1'b1);
    check_eq({name, " busy_idle"}, busy, 1'b0);
    check_eq({name, " out_valid_idle"}, bus.out_valid, 1'b0);
    step();
    check_eq({name, " done_one_cycle"}, done, 1'b0);
  endtask

  task automatic load_identity_job();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[k][i] = (i == k) ? 16'd1 : 16'd0;
        b_mat[k][i] = DW'(4 * k + i);
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) exp_c[r][c] = AW'(4 * r + c);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_vec     = '0;
    bus.b_vec     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset done", done, 1'b0);
    check_eq("reset in_ready", bus.in_ready, 1'b0);
    check_eq("reset out_valid", bus.out_valid, 1'b0);
    check_eq("reset out_row", bus.out_row, '0);
    check_eq("reset out_idx", bus.out_idx, '0);
    rst = 1'b1;
    step();

    // Identity A: result rows reproduce B.
    load_identity_job();
    run_job("identity", 1'b0, 4, 0, -1, 0);

    // Signed: -3 * 5 accumulated twice gives -30 everywhere.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[k][i] = 16'hFFFD;
        b_mat[k][i] = 16'd5;
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) exp_c[r][c] = 40'hFF_FFFF_FFE2;
    run_job("signed", 1'b1, 2, 0, -1, 0);

    // K=3 gap-free with a 5-cycle stall on row 1, then the same job with 2-cycle gaps.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[k][i] = DW'(3 * i + k + 1);
        b_mat[k][i] = DW'(2 * k + i + 7);
      end
    golden(1'b0, 3);
    run_job("k3_stall", 1'b0, 3, 0, 1, 5);
    run_job("k3_gaps", 1'b0, 3, 2, -1, 0);

    // Zero-depth job drains all-zero rows.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) exp_c[r][c] = '0;
    run_job("k0", 1'b0, 0, 0, -1, 0);

    // Reset asserted mid-stream after two beats.
    load_identity_job();
    i_mode  = 1'b0;
    i_k_len = KW'(4);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.a_vec    = pack_a(b);
      bus.b_vec    = pack_b(b);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    check_eq("pre_reset busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midreset busy", busy, 1'b0);
    check_eq("midreset in_ready", bus.in_ready, 1'b0);
    check_eq("midreset out_valid", bus.out_valid, 1'b0);
    check_eq("midreset done", done, 1'b0);
    check_eq("midreset out_row", bus.out_row, '0);
    check_eq("midreset out_idx", bus.out_idx, '0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("in_reset done", done, 1'b0);
    rst = 1'b1;
    step();
    run_job("after_reset", 1'b0, 4, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
